// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead add/sub with flags, valid/ready, flush and tag.
// Ports:
//   i_clk, i_reset           : clock, async active-high reset
//   i_valid/o_ready          : input handshake
//   i_a, i_b, i_op, i_cin    : operands, op (00 add, 01 sub, 10 adc, 11 sbb)
//   i_tag                    : sideband tag carried with the op
//   i_flush                  : kill all in-flight ops
//   o_valid/i_ready          : output handshake
//   o_sum, o_tag             : result and its tag
//   o_cout, o_ovf, o_zero,
//   o_neg, o_ltu, o_lt       : result flags
module cla_addsub_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG   = 2,
  parameter int GROUP = 4,
  parameter int TAG_W = 5
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [1:0]       i_op,
  input  logic             i_cin,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_zero,
  output logic             o_neg,
  output logic             o_ltu,
  output logic             o_lt,
  output logic [TAG_W-1:0] o_tag
);

  localparam int SW = WIDTH / SEG;
  localparam int NG = SW / GROUP;

  // Two-level CLA over one segment: group P/G, then
  // lookahead across groups, then carries inside groups.
  function automatic logic [SW:0] f_cla(
    input logic [SW-1:0] a,
    input logic [SW-1:0] b,
    input logic          ci
  );
    logic [SW-1:0] g;
    logic [SW-1:0] p;
    logic [SW-1:0] c;
    logic [NG:0]   gc;
    logic          gg;
    logic          gp;
    g     = a & b;
    p     = a ^ b;
    gc[0] = ci;
    for (int j = 0; j < NG; j++) begin
      gg = 1'b0;
      gp = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        gg = g[j*GROUP+i] | (p[j*GROUP+i] & gg);
        gp = gp & p[j*GROUP+i];
      end
      gc[j+1] = gg | (gp & gc[j]);
    end
    for (int j = 0; j < NG; j++) begin
      for (int i = 0; i < GROUP; i++) begin
        if (i == 0)
          c[j*GROUP] = gc[j];
        else
          c[j*GROUP+i] = g[j*GROUP+i-1]
                       | (p[j*GROUP+i-1] & c[j*GROUP+i-1]);
      end
    end
    return {gc[NG], p ^ c};
  endfunction

  logic             r_vo;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_neg;
  logic             r_ltu;
  logic             r_lt;
  logic [TAG_W-1:0] r_tag_o;
  logic             w_adv;

  assign w_adv   = !r_vo | i_ready;
  assign o_ready = w_adv;
  assign o_valid = r_vo;
  assign o_sum   = r_sum;
  assign o_cout  = r_cout;
  assign o_ovf   = r_ovf;
  assign o_zero  = r_zero;
  assign o_neg   = r_neg;
  assign o_ltu   = r_ltu;
  assign o_lt    = r_lt;
  assign o_tag   = r_tag_o;

  for (genvar k = 0; k < SEG; k++) begin : g_st
    // Operand bits not yet consumed by earlier stages.
    localparam int RW = WIDTH - k*SW;
    logic [RW-1:0]       w_a;
    logic [RW-1:0]       w_b;
    logic                w_ci;
    logic                w_op0;
    logic                w_v;
    logic [TAG_W-1:0]    w_tag;
    logic [SW:0]         w_r;
    logic [(k+1)*SW-1:0] w_s;

    if (k == 0) begin : g_in
      assign w_a   = i_a;
      assign w_b   = i_b ^ {WIDTH{i_op[0]}};
      assign w_ci  = i_op[1] ? i_cin : i_op[0];
      assign w_op0 = i_op[0];
      assign w_v   = i_valid;
      assign w_tag = i_tag;
      assign w_s   = w_r[SW-1:0];
    end else begin : g_in
      assign w_a   = g_st[k-1].g_reg.r_a;
      assign w_b   = g_st[k-1].g_reg.r_b;
      assign w_ci  = g_st[k-1].g_reg.r_c;
      assign w_op0 = g_st[k-1].g_reg.r_op0;
      assign w_v   = g_st[k-1].g_reg.r_v;
      assign w_tag = g_st[k-1].g_reg.r_tag;
      assign w_s   = {w_r[SW-1:0], g_st[k-1].g_reg.r_s};
    end

    assign w_r = f_cla(w_a[SW-1:0], w_b[SW-1:0], w_ci);

    if (k < SEG-1) begin : g_reg
      logic                r_v;
      logic                r_c;
      logic                r_op0;
      logic [RW-SW-1:0]    r_a;
      logic [RW-SW-1:0]    r_b;
      logic [TAG_W-1:0]    r_tag;
      logic [(k+1)*SW-1:0] r_s;

      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          r_v   <= 1'b0;
          r_c   <= 1'b0;
          r_op0 <= 1'b0;
          r_a   <= '0;
          r_b   <= '0;
          r_tag <= '0;
          r_s   <= '0;
        end else begin
          if (i_flush)
            r_v <= 1'b0;
          else if (w_adv)
            r_v <= w_v;
          if (w_adv) begin
            r_c   <= w_r[SW];
            r_op0 <= w_op0;
            r_a   <= w_a[RW-1:SW];
            r_b   <= w_b[RW-1:SW];
            r_tag <= w_tag;
            r_s   <= w_s;
          end
        end
      end
    end else begin : g_out
      logic w_ovf;
      logic w_neg;
      assign w_neg = w_s[WIDTH-1];
      assign w_ovf = (w_a[SW-1] == w_b[SW-1])
                   & (w_neg != w_a[SW-1]);

      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          r_vo    <= 1'b0;
          r_sum   <= '0;
          r_cout  <= 1'b0;
          r_ovf   <= 1'b0;
          r_zero  <= 1'b0;
          r_neg   <= 1'b0;
          r_ltu   <= 1'b0;
          r_lt    <= 1'b0;
          r_tag_o <= '0;
        end else begin
          if (i_flush)
            r_vo <= 1'b0;
          else if (w_adv)
            r_vo <= w_v;
          if (w_adv) begin
            r_sum   <= w_s;
            r_cout  <= w_r[SW];
            r_ovf   <= w_ovf;
            r_zero  <= (w_s == '0);
            r_neg   <= w_neg;
            r_ltu   <= w_op0 & !w_r[SW];
            r_lt    <= w_op0 & (w_neg ^ w_ovf);
            r_tag_o <= w_tag;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Scoreboard bench for cla_addsub_pipe in 32/2/4 and 64/4/4 forms.
// Directed cases plus randomized traffic against an arithmetic model.
module tb_cla_addsub_pipe;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
    logic        ltu;
    logic        lt;
    logic [4:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        iv32, or32, ov32, ir32, fl32, cin32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, s32;
  logic [4:0]  tg32, ot32;
  logic        c32, ovf32, z32, n32, ltu32, lt32;

  logic        iv64, or64, ov64, ir64, fl64, cin64;
  logic [1:0]  op64;
  logic [63:0] a64, b64, s64;
  logic [4:0]  tg64, ot64;
  logic        c64, ovf64, z64, n64, ltu64, lt64;

  cla_addsub_pipe #(.WIDTH(32), .SEG(2), .GROUP(4), .TAG_W(5)) u32 (
    .i_clk(clk), .i_reset(rst), .i_valid(iv32), .o_ready(or32),
    .i_a(a32), .i_b(b32), .i_op(op32), .i_cin(cin32), .i_tag(tg32),
    .i_flush(fl32), .o_valid(ov32), .i_ready(ir32), .o_sum(s32),
    .o_cout(c32), .o_ovf(ovf32), .o_zero(z32), .o_neg(n32),
    .o_ltu(ltu32), .o_lt(lt32), .o_tag(ot32)
  );

  cla_addsub_pipe #(.WIDTH(64), .SEG(4), .GROUP(4), .TAG_W(5)) u64 (
    .i_clk(clk), .i_reset(rst), .i_valid(iv64), .o_ready(or64),
    .i_a(a64), .i_b(b64), .i_op(op64), .i_cin(cin64), .i_tag(tg64),
    .i_flush(fl64), .o_valid(ov64), .i_ready(ir64), .o_sum(s64),
    .o_cout(c64), .o_ovf(ovf64), .o_zero(z64), .o_neg(n64),
    .o_ltu(ltu64), .o_lt(lt64), .o_tag(ot64)
  );

  int   n_chk = 0;
  int   n_fail = 0;
  int   pops32 = 0;
  int   pops64 = 0;
  bit   rnd = 0;
  exp_t q32[$];
  exp_t q64[$];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cmp(string p, exp_t a, exp_t e);
    chk({p, "_sum"}, a.sum, e.sum);
    chk({p, "_cout"}, a.cout, e.cout);
    chk({p, "_ovf"}, a.ovf, e.ovf);
    chk({p, "_zero"}, a.zero, e.zero);
    chk({p, "_neg"}, a.neg, e.neg);
    chk({p, "_ltu"}, a.ltu, e.ltu);
    chk({p, "_lt"}, a.lt, e.lt);
    chk({p, "_tag"}, a.tag, e.tag);
  endtask

  // Plain integer arithmetic on wide signed values.
  function automatic exp_t model(int w, logic [63:0] a, logic [63:0] b,
                                 logic [1:0] op, logic c, logic [4:0] tg);
    exp_t e;
    logic [63:0] m;
    logic signed [67:0] ua, ub, sa, sb, ci, ur, tr, two, mx, mn;
    m   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    two = 68'sd1 <<< w;
    mx  = (two >>> 1) - 1;
    mn  = -(two >>> 1);
    ua  = {4'd0, a & m};
    ub  = {4'd0, b & m};
    sa  = a[w-1] ? ua - two : ua;
    sb  = b[w-1] ? ub - two : ub;
    ci  = {67'd0, (op[1] ? c : op[0])};
    if (op[0]) begin
      ur     = ua - ub - (1 - ci);
      tr     = sa - sb - (1 - ci);
      e.cout = (ur >= 0);
      e.ltu  = (ur < 0);
      e.lt   = (tr < 0);
    end else begin
      ur     = ua + ub + ci;
      tr     = sa + sb + ci;
      e.cout = (ur >= two);
      e.ltu  = 1'b0;
      e.lt   = 1'b0;
    end
    e.sum  = ur[63:0] & m;
    e.ovf  = (tr > mx) || (tr < mn);
    e.zero = (e.sum == 64'd0);
    e.neg  = e.sum[w-1];
    e.tag  = tg;
    return e;
  endfunction

  function automatic logic [63:0] rv(int w);
    logic [63:0] m;
    logic [63:0] x;
    m = (w == 64) ? '1 : 64'hFFFF_FFFF;
    x = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: x = 64'd0;
      1: x = m;
      2: x = 64'd1 << (w-1);
      3: x = (64'd1 << (w-1)) - 64'd1;
      4: x = 64'd1;
      default: ;
    endcase
    return x & m;
  endfunction

  // Called at posedge+1; returns at posedge+1 after acceptance.
  task automatic issue(bit w, logic [63:0] a, logic [63:0] b,
                       logic [1:0] op, logic c, logic [4:0] tg, exp_t e);
    bit r;
    int n = 0;
    if (w) begin
      iv64 = 1; a64 = a; b64 = b; op64 = op; cin64 = c; tg64 = tg;
    end else begin
      iv32 = 1; a32 = a[31:0]; b32 = b[31:0];
      op32 = op; cin32 = c; tg32 = tg;
    end
    forever begin
      @(negedge clk);
      r = w ? or64 : or32;
      @(posedge clk);
      #1;
      if (r) break;
      n++;
      if (n > 1000) break;
    end
    chk("accept_timeout", r, 1);
    if (r) begin
      if (w) q64.push_back(e);
      else q32.push_back(e);
    end
    iv32 = 0;
    iv64 = 0;
  endtask

  task automatic send(bit w, logic [63:0] a, logic [63:0] b,
                      logic [1:0] op, logic c, logic [4:0] tg);
    issue(w, a, b, op, c, tg, model(w ? 64 : 32, a, b, op, c, tg));
  endtask

  task automatic lat(bit w, logic [63:0] a, logic [63:0] b,
                     logic [1:0] op, logic c, logic [4:0] tg,
                     exp_t e, int l);
    int n = 0;
    issue(w, a, b, op, c, tg, e);
    do begin
      @(negedge clk);
      n++;
    end while (!(w ? ov64 : ov32) && n < 20);
    chk(w ? "lat64" : "lat32", n, l);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((q32.size() != 0 || q64.size() != 0) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", n < 5000, 1);
  endtask

  exp_t snap32, snap64;
  bit   st32 = 0;
  bit   st64 = 0;

  always @(negedge clk) begin
    exp_t cur;
    exp_t e;
    cur = '{sum: {32'd0, s32}, cout: c32, ovf: ovf32, zero: z32,
            neg: n32, ltu: ltu32, lt: lt32, tag: ot32};
    if (rst) st32 = 0;
    else begin
      chk("rdy32", or32, !ov32 || ir32);
      if (st32) begin
        chk("hold32_v", ov32, 1);
        cmp("hold32", cur, snap32);
      end
      if (ov32 && ir32) begin
        chk("q32_nonempty", q32.size() != 0, 1);
        if (q32.size() != 0) begin
          e = q32.pop_front();
          cmp("out32", cur, e);
          pops32++;
        end
      end
      st32 = ov32 && !ir32 && !fl32;
      snap32 = cur;
    end
  end

  always @(negedge clk) begin
    exp_t cur;
    exp_t e;
    cur = '{sum: s64, cout: c64, ovf: ovf64, zero: z64,
            neg: n64, ltu: ltu64, lt: lt64, tag: ot64};
    if (rst) st64 = 0;
    else begin
      chk("rdy64", or64, !ov64 || ir64);
      if (st64) begin
        chk("hold64_v", ov64, 1);
        cmp("hold64", cur, snap64);
      end
      if (ov64 && ir64) begin
        chk("q64_nonempty", q64.size() != 0, 1);
        if (q64.size() != 0) begin
          e = q64.pop_front();
          cmp("out64", cur, e);
          pops64++;
        end
      end
      st64 = ov64 && !ir64 && !fl64;
      snap64 = cur;
    end
  end

  always @(posedge clk) begin
    if (rnd) begin
      #1;
      ir32 = ($urandom_range(0, 3) != 0);
      ir64 = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int p0;
    rst = 1;
    iv32 = 0; ir32 = 1; fl32 = 0; cin32 = 0; op32 = 0;
    a32 = 0; b32 = 0; tg32 = 0;
    iv64 = 0; ir64 = 1; fl64 = 0; cin64 = 0; op64 = 0;
    a64 = 0; b64 = 0; tg64 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_v32", ov32, 0);
    chk("rst_rdy32", or32, 1);
    chk("rst_sum32", s32, 0);
    chk("rst_zero32", z32, 0);
    chk("rst_v64", ov64, 0);
    @(posedge clk);
    #3 rst = 0;
    @(posedge clk);
    #1;

    lat(0, 64'hFFFF_FFFF, 64'h1, 2'b00, 0, 5'd3,
        '{sum: 64'h0, cout: 1, ovf: 0, zero: 1, neg: 0,
          ltu: 0, lt: 0, tag: 5'd3}, 2);
    issue(0, 64'd5, 64'd7, 2'b01, 0, 5'd4,
          '{sum: 64'hFFFF_FFFE, cout: 0, ovf: 0, zero: 0, neg: 1,
            ltu: 1, lt: 1, tag: 5'd4});
    issue(0, 64'h8000_0000, 64'd1, 2'b01, 0, 5'd5,
          '{sum: 64'h7FFF_FFFF, cout: 1, ovf: 1, zero: 0, neg: 0,
            ltu: 0, lt: 1, tag: 5'd5});
    issue(0, 64'h7FFF_FFFF, 64'd1, 2'b00, 0, 5'd6,
          '{sum: 64'h8000_0000, cout: 0, ovf: 1, zero: 0, neg: 1,
            ltu: 0, lt: 0, tag: 5'd6});
    issue(0, 64'h0000_FFFF, 64'h0001_0000, 2'b10, 1, 5'd7,
          '{sum: 64'h0002_0000, cout: 0, ovf: 0, zero: 0, neg: 0,
            ltu: 0, lt: 0, tag: 5'd7});
    drain();

    p0 = pops32;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(0, 64'(32'h1000 * (i+1)), 64'(i*3), 2'(i % 4),
               1'(i % 2), 5'(10+i));
      end
      begin
        int n = 0;
        while (!(ov32 && pops32 == p0 + 1) && n < 50) begin
          @(posedge clk);
          #1;
          n++;
        end
        chk("stall_seen", n < 50, 1);
        ir32 = 0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_rdy", or32, 0);
          @(posedge clk);
          #1;
        end
        ir32 = 1;
      end
    join
    drain();
    chk("stall_cnt", pops32 - p0, 6);

    send(0, 64'd11, 64'd22, 2'b00, 0, 5'd20);
    send(0, 64'd33, 64'd44, 2'b01, 0, 5'd21);
    ir32 = 0; fl32 = 1; iv32 = 1;
    a32 = 32'd99; b32 = 32'd1; op32 = 2'b00; tg32 = 5'd22;
    @(posedge clk);
    #1;
    fl32 = 0; iv32 = 0; ir32 = 1;
    q32.delete();
    @(negedge clk);
    chk("flush_v", ov32, 0);
    repeat (4) @(posedge clk);
    #1;
    issue(0, 64'd3, 64'd4, 2'b00, 0, 5'd23,
          '{sum: 64'd7, cout: 0, ovf: 0, zero: 0, neg: 0,
            ltu: 0, lt: 0, tag: 5'd23});
    drain();

    send(0, 64'h1234, 64'h1, 2'b00, 0, 5'd24);
    send(0, 64'h5678, 64'h2, 2'b00, 0, 5'd25);
    #2 rst = 1;
    #1;
    chk("mrst_v", ov32, 0);
    chk("mrst_sum", s32, 0);
    chk("mrst_tag", ot32, 0);
    chk("mrst_flags", {c32, ovf32, z32, n32, ltu32, lt32}, 0);
    chk("mrst_rdy", or32, 1);
    q32.delete();
    @(posedge clk);
    #3 rst = 0;
    @(posedge clk);
    #1;
    send(0, 64'd8, 64'd8, 2'b01, 1, 5'd26);
    drain();

    lat(1, 64'h0000_0000_FFFF_FFFF, 64'h1, 2'b00, 0, 5'd9,
        '{sum: 64'h0000_0001_0000_0000, cout: 0, ovf: 0, zero: 0,
          neg: 0, ltu: 0, lt: 0, tag: 5'd9}, 4);
    drain();

    rnd = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        @(posedge clk);
        #1;
      end
      send(0, rv(32), rv(32), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    end
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        @(posedge clk);
        #1;
      end
      send(1, rv(64), rv(64), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    end
    rnd = 0;
    @(posedge clk);
    #2;
    ir32 = 1;
    ir64 = 1;
    drain();
    chk("q32_empty", q32.size(), 0);
    chk("q64_empty", q64.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
